// File: rtl/fp_normalize_round.sv
// Normalize-and-round stage of the binary32 adder: a normalize stage feeds a
// round-to-nearest-even stage, with valid/ready flow control on both sides.
module fp_normalize_round (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [24:0] mant_in,
  input  logic [2:0]  grs_in,
  input  logic [7:0]  lz_count,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact,
  output logic        zero
);

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv;

  logic               s1_sign, s1_zero, s1_uf, s1_zinx;
  logic signed [9:0]  s1_exp;
  logic [23:0]        s1_mant;
  logic [2:0]         s1_grs;

  logic               n1_zero, n1_uf, n1_zinx;
  logic signed [9:0]  n1_exp;
  logic [23:0]        n1_mant;
  logic [2:0]         n1_grs;
  logic signed [9:0]  exp_ext;
  logic [4:0]         shamt;
  logic [26:0]        ext;

  logic               round_up, frac_carry, mant_carry;
  logic [22:0]        r_frac;
  logic signed [9:0]  r_exp;
  logic [31:0]        n2_result;
  logic               n2_ov, n2_uf, n2_inx, n2_zero;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  assign exp_ext = $signed({2'b00, exp_in});
  assign shamt   = (lz_count > 8'd24) ? 5'd24 : lz_count[4:0];
  assign ext     = {mant_in[23:0], grs_in} << shamt;

  // Exponent is tracked 10-bit signed so a left shift past the bottom shows up as e <= 0.
  always_comb begin
    n1_mant = ext[26:3];
    n1_grs  = ext[2:0];
    n1_exp  = exp_ext - $signed({5'b00000, shamt});
    n1_zero = 1'b0;
    n1_uf   = 1'b0;
    n1_zinx = 1'b0;
    if (mant_in == 25'd0) begin
      n1_zero = 1'b1;
      n1_zinx = |grs_in;
      n1_mant = 24'd0;
      n1_grs  = 3'd0;
      n1_exp  = 10'sd0;
    end else if (mant_in[24]) begin
      n1_mant = mant_in[24:1];
      n1_grs  = {mant_in[0], grs_in[2], grs_in[1] | grs_in[0]};
      n1_exp  = exp_ext + 10'sd1;
    end else if (n1_exp <= 10'sd0) begin
      n1_zero = 1'b1;
      n1_uf   = 1'b1;
      n1_zinx = 1'b1;
    end
  end

  assign round_up                = s1_grs[2] & (s1_grs[1] | s1_grs[0] | s1_mant[0]);
  assign {frac_carry, r_frac}    = {1'b0, s1_mant[22:0]} + {23'd0, round_up};
  assign mant_carry              = frac_carry & s1_mant[23];
  assign r_exp                   = mant_carry ? s1_exp + 10'sd1 : s1_exp;

  always_comb begin
    n2_result = {s1_sign, r_exp[7:0], r_frac};
    n2_ov     = 1'b0;
    n2_uf     = 1'b0;
    n2_inx    = |s1_grs;
    n2_zero   = 1'b0;
    if (s1_zero) begin
      n2_result = {s1_sign, 31'd0};
      n2_uf     = s1_uf;
      n2_inx    = s1_zinx;
      n2_zero   = 1'b1;
    end else if (r_exp >= 10'sd255) begin
      n2_result = {s1_sign, 8'hFF, 23'd0};
      n2_ov     = 1'b1;
      n2_inx    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      result    <= 32'd0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= sign_in;
          s1_exp  <= n1_exp;
          s1_mant <= n1_mant;
          s1_grs  <= n1_grs;
          s1_zero <= n1_zero;
          s1_uf   <= n1_uf;
          s1_zinx <= n1_zinx;
        end
      end
      // Output registers only load on advance, so a stalled result stays bit-stable.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result    <= n2_result;
          overflow  <= n2_ov;
          underflow <= n2_uf;
          inexact   <= n2_inx;
          zero      <= n2_zero;
        end
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed test-plan beats plus randomized traffic
// with random backpressure, scored against an arithmetic reference model.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [24:0] mant_in;
  logic [2:0]  grs_in;
  logic [7:0]  lz_count;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, inexact, zero;

  int total = 0;
  int bad   = 0;

  logic [35:0] exp_q[$];
  logic [35:0] obs;
  logic [35:0] held;
  logic [35:0] want;
  bit          have_held = 0;
  bit          stim_done = 0;

  assign obs = {result, overflow, underflow, inexact, zero};

  fp_normalize_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .grs_in    (grs_in),
    .lz_count  (lz_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .inexact   (inexact),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp_v);
    total++;
    assert (got === exp_v) else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp_v);
    end
  endtask

  // Reference: treat {mant,grs} as an integer, drop the low bits and round by
  // comparing the dropped remainder against exactly one half.
  function automatic logic [35:0] ref_model(input logic s, input logic [7:0] ex,
                                            input logic [24:0] mt, input logic [2:0] g,
                                            input logic [7:0] lz);
    longint full, keep, rem, half;
    int e, k;
    logic [23:0] kv;
    full = longint'({mt, g});
    if (mt == 25'd0) return {s, 31'd0, 1'b0, 1'b0, |g, 1'b1};
    if (mt[24]) begin
      keep = full >> 4;
      rem  = full & 64'hF;
      half = 8;
      e    = int'(ex) + 1;
    end else begin
      k    = (lz > 8'd24) ? 24 : int'(lz);
      full = (full << k) & 64'h7FF_FFFF;
      keep = full >> 3;
      rem  = full & 64'h7;
      half = 4;
      e    = int'(ex) - k;
      if (e <= 0) return {s, 31'd0, 1'b0, 1'b1, 1'b1, 1'b1};
    end
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (64'd1 << 24)) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    kv = keep[23:0];
    return {s, 8'(e), kv[22:0], 1'b0, 1'b0, rem != 0, 1'b0};
  endfunction

  function automatic logic [7:0] true_lz(input logic [23:0] m);
    int n = 0;
    for (int i = 23; i >= 0; i--) begin
      if (m[i]) break;
      n++;
    end
    return 8'(n);
  endfunction

  // Scoreboard: beats are recorded when accepted and retired in order on transfer.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      have_held = 0;
    end else begin
      if (have_held) begin
        check("hold_valid", {35'd0, out_valid}, 36'd1);
        check("hold_data", obs, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", {35'd0, out_valid}, 36'd0);
        else begin
          want = exp_q.pop_front();
          check("stream", obs, want);
        end
      end
      have_held = out_valid && !out_ready;
      held      = obs;
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(sign_in, exp_in, mant_in, grs_in, lz_count));
    end
  end

  task automatic applyStimulus(input logic s, input logic [7:0] e, input logic [24:0] m,
                               input logic [2:0] g, input logic [7:0] lz);
    int waited = 0;
    bit done = 0;
    sign_in  = s;
    exp_in   = e;
    mant_in  = m;
    grs_in   = g;
    lz_count = lz;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited >= 100) begin
          check("accept_timeout", {35'd0, in_ready}, 36'd1);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic s, input logic [7:0] e,
                             input logic [24:0] m, input logic [2:0] g, input logic [7:0] lz,
                             input logic [31:0] r, input logic [3:0] f);
    applyStimulus(s, e, m, g, lz);
    idle();
    check({tag, "_early"}, {35'd0, out_valid}, 36'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {35'd0, out_valid}, 36'd1);
    check({tag, "_result"}, {4'd0, result}, {4'd0, r});
    check({tag, "_flags"}, {32'd0, overflow, underflow, inexact, zero}, {32'd0, f});
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 36'(exp_q.size()), 36'd0);
  endtask

  initial begin
    logic        rs;
    logic [7:0]  re;
    logic [24:0] rm;
    logic [23:0] base;
    logic [2:0]  rg;
    logic [7:0]  rl;
    int          kind;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign_in = 1'b0; exp_in = 8'd0; mant_in = 25'd0; grs_in = 3'd0; lz_count = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {35'd0, out_valid}, 36'd0);
    check("reset_outputs", obs, 36'd0);
    rst = 1'b0;
    check("reset_in_ready", {35'd0, in_ready}, 36'd1);

    checkOutput("carry_norm", 1'b0, 8'd127, 25'h1000000, 3'b000, 8'd0, 32'h40000000, 4'b0000);
    checkOutput("left_norm",  1'b0, 8'd130, 25'h0400000, 3'b000, 8'd1, 32'h40800000, 4'b0000);
    checkOutput("round_carry", 1'b0, 8'd127, 25'h0FFFFFF, 3'b100, 8'd0, 32'h40000000, 4'b0010);
    checkOutput("tie_even",   1'b0, 8'd127, 25'h0800000, 3'b100, 8'd0, 32'h3F800000, 4'b0010);
    checkOutput("tie_odd",    1'b0, 8'd127, 25'h0800001, 3'b100, 8'd0, 32'h3F800002, 4'b0010);
    checkOutput("overflow",   1'b0, 8'd254, 25'h1000000, 3'b000, 8'd0, 32'h7F800000, 4'b1010);
    checkOutput("underflow",  1'b0, 8'd3,   25'h0040000, 3'b000, 8'd5, 32'h00000000, 4'b0111);
    checkOutput("zero_neg",   1'b1, 8'd100, 25'h0000000, 3'b000, 8'd0, 32'h80000000, 4'b0001);
    applyStimulus(1'b0, 8'd200, 25'h0000001, 3'b101, 8'd30);
    idle();
    drain("clamp_drain");

    // Backpressure: fill both stages, then hold out_ready low for three edges.
    applyStimulus(1'b0, 8'd140, 25'h1ABCDEF, 3'b011, 8'd0);
    applyStimulus(1'b1, 8'd90,  25'h0123456, 3'b110, true_lz(24'h123456));
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", {35'd0, in_ready}, 36'd0);
    held = obs;
    fork
      begin
        applyStimulus(1'b0, 8'd10, 25'h0FFFFFF, 3'b111, 8'd0);
        applyStimulus(1'b1, 8'd77, 25'h0000F00, 3'b001, true_lz(24'h000F00));
        idle();
      end
      begin
        logic [35:0] snap;
        snap = obs;
        repeat (3) begin
          @(posedge clk);
          #1;
          check("bp_stall_ready", {35'd0, in_ready}, 36'd0);
          check("bp_stall_data", obs, snap);
        end
        out_ready = 1'b1;
      end
    join
    drain("bp_drain");

    // Reset with two beats in flight; the beat presented alongside rst is dropped.
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'd120, 25'h0C00000, 3'b000, 8'd0);
    applyStimulus(1'b0, 8'd121, 25'h0A00000, 3'b000, 8'd0);
    rst = 1'b1;
    sign_in = 1'b1; exp_in = 8'd50; mant_in = 25'h1000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_out_valid", {35'd0, out_valid}, 36'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", {35'd0, out_valid}, 36'd0);
    end
    checkOutput("after_rst", 1'b1, 8'd127, 25'h1000000, 3'b000, 8'd0, 32'hC0000000, 4'b0000);
    drain("rst_drain");

    // Randomized traffic against the reference model with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          kind = $urandom_range(0, 9);
          rs   = 1'($urandom);
          rg   = 3'($urandom);
          case ($urandom_range(0, 3))
            0:       re = 8'($urandom_range(1, 30));
            1:       re = 8'($urandom_range(230, 254));
            default: re = 8'($urandom_range(1, 254));
          endcase
          if (kind == 0) begin
            rm = 25'd0;
            rl = 8'($urandom);
          end else if (kind <= 3) begin
            rm = {1'b1, 24'($urandom)};
            rl = 8'd0;
          end else begin
            base = {1'b1, 23'($urandom)};
            rm   = {1'b0, base >> $urandom_range(0, 23)};
            rl   = true_lz(rm[23:0]);
          end
          applyStimulus(rs, re, rm, rg, rl);
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk);
            #1;
          end
        end
        idle();
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
